// File: rtl/scr1_accel_arb_if.sv
// scr1_accel_arb_if -- dmem-style request/response bundle shared by the
// accelerator arbiter's two master ports and its single slave port.
//
// Parameters:
//   AWIDTH  address width
//   DWIDTH  data width
//
// Signals:
//   req      request valid (requester -> responder)
//   req_ack  request accepted (responder -> requester)
//   cmd      0 = read, 1 = write
//   width    access width (type_scr1_mem_width_e)
//   addr     address
//   wdata    write data
//   rdata    read data (responder -> requester)
//   resp     0 = NOTRDY, 1 = RDY_OK, 2 = RDY_ER
//
// Modports:
//   master   the side that issues requests
//   slave    the side that accepts requests and returns responses
interface scr1_accel_arb_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              req;
  logic              req_ack;
  logic              cmd;
  logic [1:0]        width;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic [DWIDTH-1:0] rdata;
  logic [1:0]        resp;

  modport master (
    output req, cmd, width, addr, wdata,
    input  req_ack, rdata, resp
  );

  modport slave (
    input  req, cmd, width, addr, wdata,
    output req_ack, rdata, resp
  );
endinterface

// File: rtl/scr1_accel_arb.sv
// scr1_accel_arb -- round-robin arbiter letting two masters (core data port
// and a secondary requester such as a DMA) share the accelerator's single
// dmem-style slave port, with one outstanding transaction at a time.
//
// Parameters:
//   AWIDTH   address width of all ports
//   DWIDTH   data width of all ports
//   TIMEOUT  cycles to wait for a slave response (>= 2), used only when
//            SCR1_ACCEL_ARB_TIMEOUT_EN is defined
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   m0     master 0 (core data port), slave modport
//   m1     master 1 (secondary requester), slave modport
//   s      accelerator port, master modport
//
// Optional feature (macro SCR1_ACCEL_ARB_TIMEOUT_EN): a response watchdog
// that answers the owner with RDY_ER after TIMEOUT WAIT cycles without a
// slave response. Without the macro, WAIT lasts until the slave responds.
module scr1_accel_arb #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  scr1_accel_arb_if.slave   m0,
  scr1_accel_arb_if.slave   m1,
  scr1_accel_arb_if.master  s
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [1:0] RESP_NOTRDY = 2'd0;
  localparam logic [1:0] RESP_RDY_ER = 2'd2;

  logic [0:0]        state;
  logic              owner;
  logic              last;
  logic              sel;
  logic              fwd;
  logic              any_req;
  logic              in_wait;
  logic              timeout_hit;
  logic [1:0]        owner_resp;
  logic [DWIDTH-1:0] owner_rdata;
  logic [AWIDTH-1:0] fwd_addr;
  logic [DWIDTH-1:0] fwd_wdata;

  assign any_req = m0.req | m1.req;

  // On a tie the master that was not granted last wins.
  always_comb begin
    sel = 1'b0;
    case ({m1.req, m0.req})
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last;
      default: sel = 1'b0;
    endcase
  end

  // The command path follows the live selection in IDLE and the owner in
  // WAIT, so the forwarded fields stay stable while a response is pending.
  assign fwd       = (state == WAIT) ? owner : sel;
  assign fwd_addr  = fwd ? m1.addr  : m0.addr;
  assign fwd_wdata = fwd ? m1.wdata : m0.wdata;

  assign s.addr  = fwd_addr;
  assign s.wdata = fwd_wdata;
  assign s.cmd   = fwd ? m1.cmd   : m0.cmd;
  assign s.width = fwd ? m1.width : m0.width;

  // Handshake outputs are gated by rst_n because the reset is synchronous
  // and the outputs must be quiet for the whole time it is held low.
  assign s.req      = rst_n & (state == IDLE) & any_req;
  assign m0.req_ack = s.req & s.req_ack & ~sel;
  assign m1.req_ack = s.req & s.req_ack &  sel;

`ifdef SCR1_ACCEL_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] wait_cnt;

  // Held at zero in IDLE so the first WAIT cycle counts as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign timeout_hit = (state == WAIT) && (wait_cnt == CW'(TIMEOUT - 1)) &&
                       (s.resp == RESP_NOTRDY);
`else
  assign timeout_hit = 1'b0;
`endif

  assign owner_resp  = timeout_hit ? RESP_RDY_ER : s.resp;
  assign owner_rdata = timeout_hit ? '0 : s.rdata;

  // Responses reach only the owner and only in WAIT; anything the slave
  // returns in IDLE is dropped.
  assign in_wait  = rst_n & (state == WAIT);
  assign m0.resp  = (in_wait & ~owner) ? owner_resp  : RESP_NOTRDY;
  assign m1.resp  = (in_wait &  owner) ? owner_resp  : RESP_NOTRDY;
  assign m0.rdata = (in_wait & ~owner) ? owner_rdata : '0;
  assign m1.rdata = (in_wait &  owner) ? owner_rdata : '0;

  // last resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (s.req && s.req_ack) begin
            owner <= sel;
            last  <= sel;
            state <= WAIT;
          end
        end
        WAIT: begin
          if ((s.resp != RESP_NOTRDY) || timeout_hit) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scr1_accel_arb.sv
// tb_scr1_accel_arb -- testbench for scr1_accel_arb: directed scenarios
// followed by randomized traffic, all compared cycle by cycle against a
// transaction-level model of the arbiter kept in this file.
// Define SCR1_ACCEL_ARB_TIMEOUT_EN to include the watchdog scenario.
module tb_scr1_accel_arb;

  localparam int TIMEOUT = 4;
`ifdef SCR1_ACCEL_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [1:0] NOTRDY = 2'd0;
  localparam logic [1:0] RDY_OK = 2'd1;
  localparam logic [1:0] RDY_ER = 2'd2;

  logic clk = 1'b0;
  logic rst_n;

  scr1_accel_arb_if #(.AWIDTH(32), .DWIDTH(32)) m0_if ();
  scr1_accel_arb_if #(.AWIDTH(32), .DWIDTH(32)) m1_if ();
  scr1_accel_arb_if #(.AWIDTH(32), .DWIDTH(32)) s_if ();

  scr1_accel_arb #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: is a transaction outstanding, who owns it, which master wins
  // the next tie, and how many WAIT cycles have elapsed.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_pref  = 0;
  int m_wait  = 0;

  // Masters acknowledged by the DUT, in order.
  int dut_grants[$];

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic r0,
                               input logic r1, input logic ack,
                               input logic [1:0] resp,
                               input logic [31:0] rd);
    rst_n         = rst;
    m0_if.req     = r0;
    m1_if.req     = r1;
    s_if.req_ack  = ack;
    s_if.resp     = resp;
    s_if.rdata    = rd;
  endtask

  // Checks one cycle at the falling edge, advances the model, then returns
  // just after the next rising edge so the caller can drive new inputs.
  task automatic stepCycle();
    logic        e_sreq;
    logic        e_ack0;
    logic        e_ack1;
    logic [1:0]  e_resp0;
    logic [1:0]  e_resp1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  o_resp;
    logic [31:0] o_rd;
    int          win;
    bit          timed_out;

    @(negedge clk);
    e_sreq  = 1'b0;
    e_ack0  = 1'b0;
    e_ack1  = 1'b0;
    e_resp0 = NOTRDY;
    e_resp1 = NOTRDY;
    e_rd0   = '0;
    e_rd1   = '0;
    win     = 0;

    if (!rst_n) begin
      m_busy = 1'b0;
      m_pref = 0;
      m_wait = 0;
    end else if (!m_busy) begin
      e_sreq = m0_if.req | m1_if.req;
      if (m0_if.req && m1_if.req) win = m_pref;
      else win = m1_if.req ? 1 : 0;
      if (e_sreq && s_if.req_ack) begin
        e_ack0 = (win == 0);
        e_ack1 = (win == 1);
      end
      if (e_sreq) begin
        checkOutput("s_addr",  s_if.addr,  win == 1 ? m1_if.addr  : m0_if.addr);
        checkOutput("s_wdata", s_if.wdata, win == 1 ? m1_if.wdata : m0_if.wdata);
        checkOutput("s_cmd",   s_if.cmd,   win == 1 ? m1_if.cmd   : m0_if.cmd);
        checkOutput("s_width", s_if.width, win == 1 ? m1_if.width : m0_if.width);
      end
      if (e_sreq && s_if.req_ack) begin
        m_busy  = 1'b1;
        m_owner = win;
        m_pref  = 1 - win;
        m_wait  = 0;
      end
    end else begin
      timed_out = TO_EN && (m_wait == TIMEOUT - 1) && (s_if.resp == NOTRDY);
      o_resp = timed_out ? RDY_ER : s_if.resp;
      o_rd   = timed_out ? 32'h0 : s_if.rdata;
      if (m_owner == 0) begin
        e_resp0 = o_resp;
        e_rd0   = o_rd;
      end else begin
        e_resp1 = o_resp;
        e_rd1   = o_rd;
      end
      if (s_if.resp != NOTRDY || timed_out) m_busy = 1'b0;
      else m_wait++;
    end

    checkOutput("s_req",    s_if.req,     e_sreq);
    checkOutput("m0_ack",   m0_if.req_ack, e_ack0);
    checkOutput("m1_ack",   m1_if.req_ack, e_ack1);
    checkOutput("m0_resp",  m0_if.resp,   e_resp0);
    checkOutput("m1_resp",  m1_if.resp,   e_resp1);
    checkOutput("m0_rdata", m0_if.rdata,  e_rd0);
    checkOutput("m1_rdata", m1_if.rdata,  e_rd1);

    if (m0_if.req_ack === 1'b1) dut_grants.push_back(0);
    else if (m1_if.req_ack === 1'b1) dut_grants.push_back(1);

    @(posedge clk);
    #1;
  endtask

  task automatic setMaster(input int idx, input logic cmd,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (idx == 0) begin
      m0_if.cmd = cmd; m0_if.width = 2'd2; m0_if.addr = addr; m0_if.wdata = wdata;
    end else begin
      m1_if.cmd = cmd; m1_if.width = 2'd2; m1_if.addr = addr; m1_if.wdata = wdata;
    end
  endtask

  initial begin
    int start;
    int got;
    setMaster(0, 1'b0, 32'h0, 32'h0);
    setMaster(1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, RDY_OK, 32'h1234_5678);
    repeat (2) stepCycle();

    // Single m0 read of 0x14.
    setMaster(0, 1'b0, 32'h14, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, NOTRDY, 32'h0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, RDY_OK, 32'h6a09e667);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, NOTRDY, 32'h0);
    stepCycle();

    // Simultaneous first requests after reset: m0 first, then m1.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, NOTRDY, 32'h0);
    stepCycle();
    setMaster(0, 1'b0, 32'h100, 32'h0);
    setMaster(1, 1'b0, 32'h200, 32'h0);
    for (int t = 0; t < 2; t++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, NOTRDY, 32'h0);
      stepCycle();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, RDY_OK, 32'hA0 + t);
      stepCycle();
    end

    // Continuous contention for six transactions.
    start = dut_grants.size();
    for (int t = 0; t < 6; t++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, NOTRDY, 32'h0);
      stepCycle();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, RDY_OK, 32'hB0 + t);
      stepCycle();
    end
    for (int i = 0; i < 6; i++) begin
      got = (start + i < dut_grants.size()) ? dut_grants[start + i] : 9;
      checkOutput("rr_grant", got, i % 2);
    end

    // m1 write held off by the slave for three cycles.
    setMaster(1, 1'b1, 32'h08, 32'hDEADBEEF);
    for (int t = 0; t < 3; t++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, NOTRDY, 32'h0);
      stepCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, NOTRDY, 32'h0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, RDY_OK, 32'h0);
    stepCycle();

    // Reset while m1 owns the slave; next tie goes to m0.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, NOTRDY, 32'h0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, NOTRDY, 32'h0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, RDY_OK, 32'h55);
    stepCycle();
    start = dut_grants.size();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, NOTRDY, 32'h0);
    stepCycle();
    got = (start < dut_grants.size()) ? dut_grants[start] : 9;
    checkOutput("tie_after_reset", got, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, RDY_OK, 32'h66);
    stepCycle();

`ifdef SCR1_ACCEL_ARB_TIMEOUT_EN
    // Slave never answers: watchdog reports RDY_ER, late response dropped.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, NOTRDY, 32'h0);
    stepCycle();
    for (int t = 0; t < TIMEOUT; t++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, NOTRDY, 32'h77);
      stepCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, RDY_OK, 32'h88);
    stepCycle();
`endif

    // Randomized traffic, including responses in IDLE and stray resets.
    for (int c = 0; c < 800; c++) begin
      int r;
      m0_if.cmd   = 1'($urandom_range(0, 1));
      m0_if.width = 2'($urandom_range(0, 2));
      m0_if.addr  = $urandom;
      m0_if.wdata = $urandom;
      m1_if.cmd   = 1'($urandom_range(0, 1));
      m1_if.width = 2'($urandom_range(0, 2));
      m1_if.addr  = $urandom;
      m1_if.wdata = $urandom;
      r = $urandom_range(0, 4);
      applyStimulus(($urandom_range(0, 99) >= 3),
                    ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 9) < 7),
                    (r < 2) ? NOTRDY : ((r < 4) ? RDY_OK : RDY_ER),
                    $urandom);
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
